// File: rtl/demux21_stream_if.sv
// Stream bundle for the 1-to-2 demux: one upstream port (s_*) and two
// downstream ports (a_*, b_*). slave = demux side, master = environment side.
interface demux21_stream_if #(parameter int WIDTH = 8);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_sel;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;

   modport slave (
      input  s_valid, s_data, s_sel, a_ready, b_ready,
      output s_ready, a_valid, a_data, b_valid, b_data
   );

   modport master (
      output s_valid, s_data, s_sel, a_ready, b_ready,
      input  s_ready, a_valid, a_data, b_valid, b_data
   );
endinterface

// File: rtl/demux21_stream.sv
// 1-to-2 stream demux: each output owns a 2-entry FIFO, so a stalled port
// never blocks beats bound for the other one. Per-port delivered-beat counters.
module demux21_stream #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   demux21_stream_if.slave     bus,
   output logic [7:0]          a_cnt,
   output logic [7:0]          b_cnt,
   output logic                busy
);
   localparam int PORTS = 2;

   logic [PORTS-1:0]            rdy;
   logic [PORTS-1:0]            vld;
   logic [PORTS-1:0]            full;
   logic [PORTS-1:0][WIDTH-1:0] dout;
   logic [PORTS-1:0][7:0]       cnt;
   logic                        accept;

   assign rdy = {bus.b_ready, bus.a_ready};

   // Ready depends only on registered occupancy: a full buffer refuses even
   // if it is being popped this same cycle.
   assign bus.s_ready = ~full[bus.s_sel];
   assign accept      = bus.s_valid & bus.s_ready;

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      logic [1:0]            occ;
      logic                  wp;
      logic                  rp;
      logic [7:0]            beats;
      logic [1:0][WIDTH-1:0] mem;
      logic                  push;
      logic                  pop;

      assign push = accept & (bus.s_sel == 1'(p));
      assign pop  = (occ != 2'd0) & rdy[p];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            occ   <= 2'd0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            beats <= 8'd0;
         end else begin
            if (push) wp <= ~wp;
            if (pop) begin
               rp    <= ~rp;
               beats <= beats + 8'd1;
            end
            case ({push, pop})
               2'b10:   occ <= occ + 2'd1;
               2'b01:   occ <= occ - 2'd1;
               default: occ <= occ;
            endcase
         end
      end

      // Storage is not reset; occupancy alone decides what is valid.
      always_ff @(posedge clk) begin
         if (push) mem[wp] <= bus.s_data;
      end

      assign vld[p]  = (occ != 2'd0);
      assign full[p] = (occ == 2'd2);
      assign dout[p] = mem[rp];
      assign cnt[p]  = beats;
   end

   assign bus.a_valid = vld[0];
   assign bus.a_data  = dout[0];
   assign bus.b_valid = vld[1];
   assign bus.b_data  = dout[1];
   assign a_cnt       = cnt[0];
   assign b_cnt       = cnt[1];
   assign busy        = |vld;
endmodule

// File: tb/tb_demux21_stream.sv
// Bench for demux21_stream: queue-based model of the two port buffers checked
// every cycle, plus directed scenarios with literal expectations.
module tb_demux21_stream;
   localparam int WIDTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] a_cnt, b_cnt;
   logic       busy;

   demux21_stream_if #(.WIDTH(WIDTH)) bus ();

   demux21_stream #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .a_cnt (a_cnt),
      .b_cnt (b_cnt),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: one queue per port, capacity 2, plus delivered-beat counters.
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   logic [7:0]       ma_cnt, mb_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      ma_cnt = 8'd0;
      mb_cnt = 8'd0;
   endtask

   // One clock cycle: compare at negedge, then advance the model at posedge.
   // Called with inputs already set, and returns 1 time unit after the posedge.
   task automatic step();
      bit acc, pa, pb, sel;
      logic [WIDTH-1:0] d;
      @(negedge clk);
      chk("a_valid", 32'(bus.a_valid), 32'(qa.size() != 0));
      chk("b_valid", 32'(bus.b_valid), 32'(qb.size() != 0));
      chk("busy", 32'(busy), 32'(qa.size() != 0 || qb.size() != 0));
      chk("s_ready", 32'(bus.s_ready), 32'(bus.s_sel ? qb.size() != 2 : qa.size() != 2));
      chk("a_cnt", 32'(a_cnt), 32'(ma_cnt));
      chk("b_cnt", 32'(b_cnt), 32'(mb_cnt));
      if (qa.size() != 0) chk("a_data", 32'(bus.a_data), 32'(qa[0]));
      if (qb.size() != 0) chk("b_data", 32'(bus.b_data), 32'(qb[0]));
      sel = bus.s_sel;
      d   = bus.s_data;
      acc = bus.s_valid && (sel ? qb.size() < 2 : qa.size() < 2);
      pa  = bus.a_ready && qa.size() != 0;
      pb  = bus.b_ready && qb.size() != 0;
      @(posedge clk);
      if (pa) begin void'(qa.pop_front()); ma_cnt++; end
      if (pb) begin void'(qb.pop_front()); mb_cnt++; end
      if (acc) begin
         if (sel) qb.push_back(d);
         else     qa.push_back(d);
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.s_valid = 1'b0;
      bus.s_sel   = 1'b0;
      bus.s_data  = '0;
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst a_valid", 32'(bus.a_valid), 32'd0);
      chk("rst b_valid", 32'(bus.b_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst a_cnt", 32'(a_cnt), 32'd0);
      chk("rst b_cnt", 32'(b_cnt), 32'd0);
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-rst s_ready sel0", 32'(bus.s_ready), 32'd1);
      bus.s_sel = 1'b1;
      #1;
      chk("post-rst s_ready sel1", 32'(bus.s_ready), 32'd1);
      bus.s_sel = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic sel, input logic [WIDTH-1:0] d);
      bus.s_valid = 1'b1;
      bus.s_sel   = sel;
      bus.s_data  = d;
      step();
      bus.s_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();

      // Single beat to a: one-cycle latency, then counted on pop.
      do_reset();
      bus.a_ready = 1'b1;
      push(1'b0, 8'h5A);
      chk("single a_valid", 32'(bus.a_valid), 32'd1);
      chk("single a_data", 32'(bus.a_data), 32'h5A);
      step();
      chk("single a_cnt", 32'(a_cnt), 32'd1);
      chk("single b_valid", 32'(bus.b_valid), 32'd0);

      // Fill b while stalled; third beat waits until b drains.
      do_reset();
      push(1'b1, 8'h11);
      push(1'b1, 8'h22);
      bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 8'h33;
      #1;
      chk("b full s_ready", 32'(bus.s_ready), 32'd0);
      step();
      bus.b_ready = 1'b1;
      #1;
      chk("b head 0x11", 32'(bus.b_data), 32'h11);
      chk("b full+pop s_ready", 32'(bus.s_ready), 32'd0);
      step();
      chk("b head 0x22", 32'(bus.b_data), 32'h22);
      chk("0x33 accepted", 32'(bus.s_ready), 32'd1);
      step();
      bus.s_valid = 1'b0;
      chk("b head 0x33", 32'(bus.b_data), 32'h33);
      repeat (2) step();
      chk("b drained cnt", 32'(b_cnt), 32'd3);

      // Full b does not block a.
      do_reset();
      push(1'b1, 8'h11);
      push(1'b1, 8'h22);
      bus.s_valid = 1'b1; bus.s_sel = 1'b0; bus.s_data = 8'h77;
      #1;
      chk("no HOL s_ready", 32'(bus.s_ready), 32'd1);
      step();
      bus.s_valid = 1'b0;
      chk("no HOL a_data", 32'(bus.a_data), 32'h77);
      chk("no HOL b_data", 32'(bus.b_data), 32'h11);
      chk("no HOL b_valid", 32'(bus.b_valid), 32'd1);

      // 256 back-to-back beats to a at full rate; counter wraps to 0.
      do_reset();
      bus.a_ready = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_sel   = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bus.s_data = 8'(i);
         step();
         chk("stream a_valid", 32'(bus.a_valid), 32'd1);
      end
      bus.s_valid = 1'b0;
      step();
      chk("stream a_cnt wrap", 32'(a_cnt), 32'd0);
      chk("stream a empty", 32'(bus.a_valid), 32'd0);

      // Asynchronous reset mid-cycle with two entries held in a.
      do_reset();
      bus.a_ready = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_sel   = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus.s_data = 8'(i);
         step();
      end
      bus.a_ready = 1'b0;
      bus.s_data  = 8'h04;
      step();
      bus.s_valid = 1'b0;
      chk("pre-areset a_cnt", 32'(a_cnt), 32'd2);
      chk("pre-areset full", 32'(bus.s_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset a_valid", 32'(bus.a_valid), 32'd0);
      chk("areset a_cnt", 32'(a_cnt), 32'd0);
      chk("areset busy", 32'(busy), 32'd0);
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 10000; i++) begin
         bus.s_valid = 1'($urandom_range(0, 1));
         bus.s_sel   = 1'($urandom_range(0, 1));
         bus.s_data  = 8'($urandom);
         bus.a_ready = ($urandom_range(0, 3) != 0);
         bus.b_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      bus.s_valid = 1'b0;
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      repeat (3) step();
      chk("random drained busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/demux21_stream.md
DEMUX21_STREAM -- requirements
Module: demux21_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every stream port.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 s_valid  input  1  upstream beat valid.
REQ-006 s_ready  output  1  upstream beat accepted when s_valid & s_ready.
REQ-007 s_data  input  WIDTH  upstream payload.
REQ-008 s_sel  input  1  destination: 0 = port a, 1 = port b; sampled with the beat.
REQ-009 a_valid / b_valid  output  1  head entry of the a / b buffer valid.
REQ-010 a_ready / b_ready  input  1  downstream a / b accepts the head entry.
REQ-011 a_data / b_data  output  WIDTH  head entry of the a / b buffer.
REQ-012 a_cnt / b_cnt  output  8  beats delivered on a / b, modulo 256.
REQ-013 busy  output  1  high when either buffer holds an entry.

Function
REQ-014 Each output port SHALL own an independent 2-entry FIFO buffer (storage, read pointer, write pointer, occupancy 0..2).
REQ-015 s_ready SHALL be (s_sel ? b_occ != 2 : a_occ != 2), combinational from s_sel and registered occupancy only, never from a_ready/b_ready.
REQ-016 On s_valid & s_ready, s_data SHALL be written to the buffer selected by s_sel at that edge; the other buffer is untouched.
REQ-017 Latency: a beat accepted at edge N SHALL be visible on x_valid/x_data after edge N, i.e. one cycle, when that buffer was empty.
REQ-018 x_valid SHALL equal (x_occ != 0); x_data SHALL be the oldest unread entry; x_data is don't-care when x_valid is low.
REQ-019 On x_valid & x_ready, the head SHALL be popped and x_cnt incremented by 1, wrapping 255 -> 0.
REQ-020 Simultaneous push and pop on the same buffer SHALL leave occupancy unchanged and preserve FIFO order; pop precedes the new entry in order.
REQ-021 Buffer full (occ = 2) with the same-cycle pop SHALL still deassert s_ready for that buffer; the push is not taken that cycle.
REQ-022 Pop of an empty buffer (x_ready high, x_valid low) SHALL have no effect on occupancy or counters.
REQ-023 Per-port ordering SHALL be preserved; no ordering is guaranteed between ports a and b.
REQ-024 A full buffer SHALL NOT block beats destined for the other port (no head-of-line blocking across ports).
REQ-025 Sustained throughput SHALL be one beat per cycle per port when the downstream holds ready high.
REQ-026 Pointers SHALL wrap modulo 2; occupancy SHALL never exceed 2 or underflow below 0.
REQ-027 busy SHALL equal a_valid | b_valid.

Reset
REQ-028 While rst_n is low: occupancies, pointers, a_cnt and b_cnt SHALL be 0, and a_valid, b_valid and busy SHALL be 0; buffer storage need not be cleared.
REQ-029 Reset assertion SHALL take effect immediately, without a clock; entries in flight are discarded.
REQ-030 After rst_n rises, s_ready SHALL be 1 for either s_sel value, and the first accepting edge SHALL be the first rising clk with rst_n high.

Verification
REQ-031 Reset, then s_valid=1, s_sel=0, s_data=0x5A for one cycle, a_ready=1 -> a_valid=1, a_data=0x5A the next cycle, then a_cnt=1, b_valid stays 0.
REQ-032 b_ready=0, push 0x11, 0x22, 0x33 with s_sel=1 -> s_ready low after two pushes, b_occ=2; raise b_ready -> b_data 0x11 then 0x22, then 0x33 accepted.
REQ-033 b buffer full, b_ready=0; push s_sel=0 data 0x77 -> s_ready=1, 0x77 appears on a while b is unchanged.
REQ-034 256 beats to port a, a_ready=1 throughout -> a_valid high every cycle after the first, and a_cnt returns to 0x00.
REQ-035 a buffer holds 2 entries; assert rst_n=0 asynchronously mid-cycle -> a_valid=0, a_cnt=0, busy=0 immediately; after release s_ready=1.
REQ-036 Random s_sel/s_valid/x_ready for 10k cycles against a scoreboard -> per-port order and data exact, counters match scoreboard totals mod 256.
